// File: rtl/ad2_scan_scheduler.sv
// ad2_scan_scheduler
// Round-robin conversion sequencer for the PmodAD2 (AD7991) I2C ADC.
// Every SCAN_DIV cycles it walks the enabled channels, requesting one
// conversion per sample, checks the returned channel ID and publishes a
// 12-bit result per channel.
// Optional feature macro: AD2_AVG_EN -- averages 2**AVG_LOG2 samples per
// channel per scan; without it one sample is taken and published directly.
module ad2_scan_scheduler #(
  parameter int SCAN_DIV = 100000,
  parameter int TIMEOUT  = 50000,
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ch_enable,
  output logic        conv_req,
  output logic [7:0]  cfg_byte,
  input  logic        conv_done,
  input  logic [15:0] raw_data,
  output logic [11:0] ch0,
  output logic [11:0] ch1,
  output logic [11:0] ch2,
  output logic [11:0] ch3,
  output logic [3:0]  upd,
  output logic [1:0]  err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ACC  = 2'd3
  } state_t;

  localparam int TMR_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCAN_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  // Lowest set bit of m at or above position 'from'; bit 2 set = none found.
  function automatic logic [2:0] find_from(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (3'(i) >= from)) begin
        res = {1'b0, 2'(i)};
      end
    end
    return res;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [TMR_W-1:0] timer_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic [3:0]       mask_r;
  logic [1:0]       idx_r, idx_nxt_s;
  logic             abort_r;
  logic             wrap_s, start_s, done_ok_s, to_exp_s, last_s, finish_s;
  logic [2:0]       first_s, adv_s;
  logic [11:0]      pub_val_s;
  logic             conv_req_nxt_s;
  logic [7:0]       cfg_nxt_s;
  logic [3:0]       upd_nxt_s;
  logic [1:0]       err_set_s, err_nxt_s;
  logic             unused_s;

  assign wrap_s    = (timer_r == TMR_LAST);
  assign start_s   = (state_r == S_IDLE) && wrap_s;
  assign done_ok_s = conv_done && (raw_data[13:12] == idx_r);
  assign to_exp_s  = (to_cnt_r == TO_LAST);
  assign first_s   = find_from(ch_enable, 3'd0);
  assign adv_s     = find_from(mask_r, {1'b0, idx_r} + 3'd1);
  // An aborted sample or the last sample of a channel ends the channel.
  assign finish_s  = (state_r == S_ACC) && (abort_r || last_s);
  assign unused_s  = ^{raw_data[15:14], 32'(AVG_LOG2)};

`ifdef AD2_AVG_EN
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam logic [4:0] LAST_CNT = 5'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_r;
  logic [4:0]       cnt_r;

  assign last_s    = (cnt_r >= LAST_CNT);
  assign pub_val_s = 12'(acc_r >> AVG_LOG2);

  // Sample accumulator and per-channel sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= 5'd0;
    end else if (start_s || finish_s) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= 5'd0;
    end else if ((state_r == S_WAIT) && done_ok_s) begin
      acc_r <= acc_r + ACC_W'(raw_data[11:0]);
    end else if (state_r == S_ACC) begin
      cnt_r <= cnt_r + 5'd1;
    end
  end
`else
  logic [11:0] sample_r;

  assign last_s    = 1'b1;
  assign pub_val_s = sample_r;

  // Hold the accepted sample for publication in ACC
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_r <= 12'd0;
    end else if ((state_r == S_WAIT) && done_ok_s) begin
      sample_r <= raw_data[11:0];
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; aborts pass through ACC so the next request trails the error by a cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_s && !first_s[2]) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (conv_done || to_exp_s) begin
          state_nxt_s = S_ACC;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_ACC: begin
        if (!finish_s || !adv_s[2]) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs and channel index
  always_comb begin
    idx_nxt_s = idx_r;
    if (start_s) begin
      idx_nxt_s = first_s[1:0];
    end else if (finish_s && !adv_s[2]) begin
      idx_nxt_s = adv_s[1:0];
    end else begin
      idx_nxt_s = idx_r;
    end

    conv_req_nxt_s = (state_nxt_s == S_REQ);
    if (conv_req_nxt_s) begin
      cfg_nxt_s = {4'b0001 << idx_nxt_s, 4'b0000};
    end else begin
      cfg_nxt_s = cfg_byte;
    end

    if (finish_s && !abort_r) begin
      upd_nxt_s = 4'b0001 << idx_r;
    end else begin
      upd_nxt_s = 4'b0000;
    end

    err_set_s[1] = (state_r == S_WAIT) && conv_done && !done_ok_s;
    err_set_s[0] = (state_r == S_WAIT) && !conv_done && to_exp_s;
    err_nxt_s    = (err & ~{2{err_clr}}) | err_set_s;
  end

  // Scan timer, scan mask, channel index and per-request timeout tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r  <= {TMR_W{1'b0}};
      mask_r   <= 4'b0000;
      idx_r    <= 2'd0;
      to_cnt_r <= {TO_W{1'b0}};
      abort_r  <= 1'b0;
    end else begin
      timer_r <= wrap_s ? {TMR_W{1'b0}} : timer_r + TMR_W'(1);
      if (start_s) begin
        mask_r <= ch_enable;
      end
      idx_r <= idx_nxt_s;
      if (state_r == S_REQ) begin
        to_cnt_r <= {TO_W{1'b0}};
      end else if (state_r == S_WAIT) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
      if (state_r == S_WAIT) begin
        abort_r <= !done_ok_s;
      end
    end
  end

  // Registered outputs and per-channel result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_req <= 1'b0;
      cfg_byte <= 8'h00;
      upd      <= 4'b0000;
      err      <= 2'b00;
      ch0      <= 12'd0;
      ch1      <= 12'd0;
      ch2      <= 12'd0;
      ch3      <= 12'd0;
    end else begin
      conv_req <= conv_req_nxt_s;
      cfg_byte <= cfg_nxt_s;
      upd      <= upd_nxt_s;
      err      <= err_nxt_s;
      if (upd_nxt_s[0]) ch0 <= pub_val_s;
      if (upd_nxt_s[1]) ch1 <= pub_val_s;
      if (upd_nxt_s[2]) ch2 <= pub_val_s;
      if (upd_nxt_s[3]) ch3 <= pub_val_s;
    end
  end

endmodule

// File: tb/tb_ad2_scan_scheduler.sv
// Directed, table-driven bench for ad2_scan_scheduler.
module tb_ad2_scan_scheduler;

  localparam int SCAN_DIV = 200;
  localparam int TIMEOUT  = 20;
  localparam int AVG_LOG2 = 2;
`ifdef AD2_AVG_EN
  localparam int NS = 4;
`else
  localparam int NS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ch_enable = 4'b1111;
  logic        conv_req;
  logic [7:0]  cfg_byte;
  logic        conv_done = 1'b0;
  logic [15:0] raw_data = 16'h0000;
  logic [11:0] ch0, ch1, ch2, ch3;
  logic [3:0]  upd;
  logic [1:0]  err;
  logic        err_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cnt = 0;
  int upd_cnt [4] = '{0, 0, 0, 0};

  ad2_scan_scheduler #(.SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT), .AVG_LOG2(AVG_LOG2)) dut (
    .clk(clk), .rst(rst), .ch_enable(ch_enable), .conv_req(conv_req),
    .cfg_byte(cfg_byte), .conv_done(conv_done), .raw_data(raw_data),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .upd(upd), .err(err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Count request and update pulses as seen by a downstream consumer
  always @(posedge clk) begin
    if (conv_req === 1'b1) req_cnt++;
    for (int k = 0; k < 4; k++) begin
      if (upd[k] === 1'b1) upd_cnt[k]++;
    end
  end

  typedef struct {
    logic [15:0] raw;
    logic [7:0]  exp_cfg;
    logic [3:0]  exp_upd;
    int          ch;
    logic [11:0] exp_val;
    logic [3:0]  en_after;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] get_ch(input int i);
    case (i)
      0: return ch0;
      1: return ch1;
      2: return ch2;
      default: return ch3;
    endcase
  endfunction

  // Return at a falling edge where conv_req is high, or report a timeout.
  task automatic wait_req(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (conv_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_req: no conv_req within %0d cycles, expected one", bound);
    end
  endtask

  // Called in the REQ cycle: answer in the next (WAIT) cycle, end at t+2.
  task automatic respond(input logic [15:0] raw);
    @(negedge clk);
    conv_done = 1'b1;
    raw_data  = raw;
    @(negedge clk);
    conv_done = 1'b0;
    raw_data  = 16'h0000;
    chk("upd_in_acc", {60'd0, upd}, 64'd0);
    @(negedge clk);
  endtask

  vec_t vecs [6];
  logic [15:0] avg_raw [4];

  initial begin
    bit ok;
    int base_req;
    int base_upd;
    logic [11:0] ch0_keep, ch3_keep;

    vecs[0] = '{16'h0064, 8'h10, 4'b0001, 0, 12'd100,  4'hF};
    vecs[1] = '{16'h10C8, 8'h20, 4'b0010, 1, 12'd200,  4'hF};
    vecs[2] = '{16'h212C, 8'h40, 4'b0100, 2, 12'd300,  4'hF};
    vecs[3] = '{16'h3190, 8'h80, 4'b1000, 3, 12'd400,  4'hA};
    vecs[4] = '{16'h1FFF, 8'h20, 4'b0010, 1, 12'hFFF,  4'hA};
    vecs[5] = '{16'hF001, 8'h80, 4'b1000, 3, 12'h001,  4'h0};
    avg_raw[0] = 16'h100A;
    avg_raw[1] = 16'h100B;
    avg_raw[2] = 16'h100C;
    avg_raw[3] = 16'h100E;

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_outputs", {1'b0, conv_req, cfg_byte, ch0, ch1, ch2, ch3, upd, err}, 64'd0);
    rst = 1'b0;

    // First scan: conv_req exactly SCAN_DIV cycles after reset release
    repeat (SCAN_DIV - 1) @(negedge clk);
    chk("first_req_early", {63'd0, conv_req}, 64'd0);
    @(negedge clk);
    chk("first_req_time", {63'd0, conv_req}, 64'd1);

    // Table: scan A (mask 1111) then scan B (mask 1010)
    for (int v = 0; v < 6; v++) begin
      for (int s = 0; s < NS; s++) begin
        wait_req(2 * SCAN_DIV, ok);
        if (!ok) break;
        chk($sformatf("cfg_row%0d", v), {56'd0, cfg_byte}, {56'd0, vecs[v].exp_cfg});
        respond(vecs[v].raw);
        if (s == NS - 1) begin
          chk($sformatf("upd_row%0d", v), {60'd0, upd}, {60'd0, vecs[v].exp_upd});
          chk($sformatf("ch_row%0d", v), {52'd0, get_ch(vecs[v].ch)}, {52'd0, vecs[v].exp_val});
        end else begin
          chk($sformatf("upd_mid_row%0d", v), {60'd0, upd}, 64'd0);
        end
      end
      ch_enable = vecs[v].en_after;
    end
    repeat (4) @(negedge clk);
    chk("table_req_count", 64'(req_cnt), 64'(6 * NS));
    chk("table_upd_counts", {32'd0, 8'(upd_cnt[3]), 8'(upd_cnt[2]), 8'(upd_cnt[1]), 8'(upd_cnt[0])},
        {32'd0, 8'd2, 8'd1, 8'd2, 8'd1});

    // ch1 alone: averaging of 10, 11, 12, 14 (or a single sample of 10)
    base_req  = req_cnt;
    base_upd  = upd_cnt[1];
    ch_enable = 4'b0010;
    for (int s = 0; s < NS; s++) begin
      wait_req(2 * SCAN_DIV, ok);
      if (!ok) break;
      if (s == 0) ch_enable = 4'b0000;
      chk("avg_cfg", {56'd0, cfg_byte}, 64'h20);
      respond(avg_raw[s]);
    end
`ifdef AD2_AVG_EN
    chk("avg_ch1", {52'd0, ch1}, 64'd11);
`else
    chk("avg_ch1", {52'd0, ch1}, 64'd10);
`endif
    repeat (10) @(negedge clk);
    chk("avg_req_count", 64'(req_cnt - base_req), 64'(NS));
    chk("avg_upd_once", 64'(upd_cnt[1] - base_upd), 64'd1);

    // Mask 0101, ch0 never answers: timeout, then ch2
    ch0_keep  = ch0;
    ch_enable = 4'b0101;
    wait_req(2 * SCAN_DIV, ok);
    ch_enable = 4'b0000;
    chk("to_cfg_ch0", {56'd0, cfg_byte}, 64'h10);
    repeat (TIMEOUT) @(negedge clk);
    chk("to_err_early", {62'd0, err}, 64'd0);
    @(negedge clk);
    chk("to_err_set", {62'd0, err}, 64'd1);
    chk("to_no_req_yet", {63'd0, conv_req}, 64'd0);
    @(negedge clk);
    chk("to_next_req", {63'd0, conv_req}, 64'd1);
    chk("to_cfg_ch2", {56'd0, cfg_byte}, 64'h40);
    for (int s = 0; s < NS; s++) begin
      wait_req(2 * SCAN_DIV, ok);
      if (!ok) break;
      respond(16'h2555);
    end
    chk("to_ch2", {52'd0, ch2}, 64'h555);
    chk("to_ch0_kept", {52'd0, ch0}, {52'd0, ch0_keep});
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_err_clr", {62'd0, err}, 64'd0);

    // ch3 returns ID 1: mismatch; err_clr in the same cycle must not win
    ch3_keep  = ch3;
    base_req  = req_cnt;
    ch_enable = 4'b1000;
    wait_req(2 * SCAN_DIV, ok);
    ch_enable = 4'b0000;
    chk("mm_cfg", {56'd0, cfg_byte}, 64'h80);
    @(negedge clk);
    conv_done = 1'b1;
    raw_data  = 16'h1ABC;
    err_clr   = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    raw_data  = 16'h0000;
    err_clr   = 1'b0;
    chk("mm_err_set", {62'd0, err}, 64'd2);
    @(negedge clk);
    chk("mm_no_upd", {60'd0, upd}, 64'd0);
    chk("mm_ch3_kept", {52'd0, ch3}, {52'd0, ch3_keep});
    repeat (40) @(negedge clk);
    chk("mm_idle_one_req", 64'(req_cnt - base_req), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("mm_err_clr", {62'd0, err}, 64'd0);

    // Reset in WAIT, followed by a late conv_done
    ch_enable = 4'b0001;
    wait_req(2 * SCAN_DIV, ok);
    ch_enable = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    conv_done = 1'b1;
    raw_data  = 16'h0777;
    @(negedge clk);
    conv_done = 1'b0;
    raw_data  = 16'h0000;
    chk("rst_outputs", {1'b0, conv_req, cfg_byte, ch0, ch1, ch2, ch3, upd, err}, 64'd0);
    base_req = req_cnt;
    base_upd = upd_cnt[0] + upd_cnt[1] + upd_cnt[2] + upd_cnt[3];
    repeat (3 * SCAN_DIV) @(negedge clk);
    chk("mask0_no_req", 64'(req_cnt - base_req), 64'd0);
    chk("mask0_no_upd", 64'(upd_cnt[0] + upd_cnt[1] + upd_cnt[2] + upd_cnt[3] - base_upd), 64'd0);
    chk("mask0_ch0", {52'd0, ch0}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ad2_scan_scheduler.md
# ad2_scan_scheduler

Sequences conversions on the PmodAD2 (AD7991) I2C ADC for the 4-channel voltage display path. It scans the enabled channels round-robin at a fixed rate and issues one conversion request per sample to the I2C master, together with the matching configuration byte. It checks each returned sample's channel ID, optionally averages consecutive samples, and publishes per-channel 12-bit results for the bin2bcd converters.

## Interface
- SCAN_DIV, 100000: clock cycles between scan starts (≥ 16).
- TIMEOUT, 50000: maximum cycles in WAIT for `conv_done` before abort.
- AVG_LOG2, 2: log2 of samples averaged per channel per scan (0–4); used only with AD2_AVG_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ch_enable  in  4  channel enable mask, bit n = channel n; sampled only at scan start.
- conv_req  out  1  one-cycle pulse requesting one I2C config-write and read transaction.
- cfg_byte  out  8  AD7991 config byte: [7:4] one-hot channel select (bit 4+n = ch n), [3:0] = 4'b0000.
- conv_done  in  1  one-cycle pulse: `raw_data` is valid.
- raw_data  in  16  AD7991 word: [13:12] channel ID, [11:0] result.
- ch0, ch1, ch2, ch3  out  12 each  latest published result per channel.
- upd  out  4  one-cycle pulse per channel when its result register updates.
- err  out  2  sticky flags: [0] timeout, [1] channel-ID mismatch.
- err_clr  in  1  clears `err`.

## Operation
- FSM states: IDLE, REQ, WAIT, ACC.
- IDLE:
  - The scan timer counts 0..SCAN_DIV-1 and wraps; it runs continuously from reset in every state.
  - At the wrap, if in IDLE: latch `ch_enable` into `mask`, set `idx` = lowest set bit of `mask`, clear the sample counter and accumulator, then go to REQ.
  - If `mask` = 0, stay in IDLE and issue no request.
- A wrap that occurs outside IDLE is dropped; the scan is not queued.
- REQ (1 cycle):
  - `conv_req` = 1.
  - `cfg_byte` = {one-hot(idx), 4'b0000}.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - If `conv_done` = 1 and `raw_data[13:12]` == `idx`: go to ACC and add `raw_data[11:0]` to the accumulator.
  - If `conv_done` = 1 with an ID mismatch: set `err[1]`, discard the accumulator for `idx`, and advance to the next channel.
  - If the timeout counter reaches TIMEOUT-1 with no `conv_done`: set `err[0]`, discard the accumulator, and advance to the next channel.
  - `conv_done` in the same cycle as timeout expiry: `conv_done` wins.
- ACC (1 cycle):
  - If the sample count < 2^AVG_LOG2 - 1: increment the count and go to REQ with the same `idx`.
  - Otherwise: publish `ch[idx]` = accumulator >> AVG_LOG2 (truncating), pulse `upd[idx]`, and advance.
- Advance:
  - Next `idx` = next set bit of `mask` strictly above the current `idx`, searched upward; clear count and accumulator, then go to REQ.
  - If no higher set bit exists, go to IDLE.
- Accumulator width is 12+AVG_LOG2 bits, so no overflow is possible.
- `conv_done` outside WAIT is ignored.
- `err` bits are set on their events and cleared by `err_clr`; a set and a clear in the same cycle leaves the bit set.
- Reset values:
  - State IDLE; timer, counters and accumulator = 0.
  - `conv_req` = 0, `cfg_byte` = 8'h00.
  - `ch0`–`ch3` = 0, `upd` = 0, `err` = 0.
- `rst` during any state aborts the transaction immediately and applies the reset values. A late `conv_done` after reset is ignored, since the FSM is in IDLE.

## Timing
- The first scan starts at the wrap SCAN_DIV-1 cycles after reset deasserts; `conv_req` is high on the following cycle.
- `cfg_byte` is valid from the REQ cycle and held stable until WAIT exits.
- `conv_done` sampled at cycle t:
  - ACC in cycle t+1; `ch[idx]` and `upd[idx]` are registered and visible in cycle t+2.
  - The next `conv_req` is high in cycle t+2.
- Timeout: `err[0]` is visible TIMEOUT+1 cycles after `conv_req`; the next channel's `conv_req` follows 1 cycle later.

## Configuration
- `AD2_AVG_EN` defined:
  - Averaging over 2^AVG_LOG2 samples as described above.
- `AD2_AVG_EN` undefined:
  - AVG_LOG2 is ignored and one sample is taken per channel per scan.
  - ACC always publishes `raw_data[11:0]` directly, and the accumulator logic is removed.

## Test plan
- Mask 4'b1111, AVG off, model returns ID-correct values 100/200/300/400:
  - Exactly 4 `conv_req` per scan with `cfg_byte` 8'h10, 8'h20, 8'h40, 8'h80.
  - `ch0`–`ch3` = 100/200/300/400; each `upd` pulses once, 2 cycles after its `conv_done`.
- AD2_AVG_EN, AVG_LOG2 = 2, ch1 only, samples 10, 11, 12, 14:
  - 4 requests with `cfg_byte` 8'h20; `ch1` = 11 (47 >> 2); `upd[1]` pulses once.
- Mask 4'b0101, model never responds on ch0:
  - `err[0]` set after TIMEOUT cycles; ch2 then requested and updated; `ch0` unchanged.
- ch3 enabled, `raw_data` = 16'h1ABC (ID 1):
  - `err[1]` set, `ch3` unchanged, return to IDLE.
  - `err_clr` pulse clears `err` to 0.
- `rst` asserted mid-WAIT, then `conv_done` arrives:
  - All outputs at reset values; no `upd` pulse.
  - Mask 0: no `conv_req` across 3 scan periods.
